// File: rtl/rca_lsu_request_queue_pkg.sv
// Shared configuration and request layout for the RCA load/store request path.
package rca_lsu_request_queue_pkg;

  localparam int RCA_XLEN                  = 32;
  localparam int RCA_ID_W                  = 3;
  localparam int RCA_LS_QUEUE_DEPTH        = 4;
  localparam int RCA_MAX_OUTSTANDING_LOADS = 4;

  typedef struct packed {
    logic [RCA_XLEN-1:0] rs1;
    logic [RCA_XLEN-1:0] rs2;
    logic [2:0]          fn3;
    logic                load;
    logic                store;
    logic [RCA_ID_W-1:0] id;
  } rca_ls_request_t;

  // A request must be exactly one of load or store.
  function automatic logic is_malformed(input logic load, input logic store);
    return load == store;
  endfunction

endpackage

// File: rtl/rca_ls_request_fifo.sv
// Circular buffer of LS requests; pointers carry a wrap bit to tell full from empty.
// Head reads as zero when empty; flush resets both pointers at the next edge.
module rca_ls_request_fifo
  import rca_lsu_request_queue_pkg::*;
#(
  parameter type entry_t = rca_ls_request_t,
  parameter int  DEPTH   = RCA_LS_QUEUE_DEPTH
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  input  logic   flush,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rca_lsu_request_queue.sv
// Queues RCA grid load/store requests and issues them in order to the LSU, limiting
// outstanding loads, returning load data one cycle late and holding the LSU lock.
module rca_lsu_request_queue
  import rca_lsu_request_queue_pkg::*;
#(
  parameter int XLEN      = RCA_XLEN,
  parameter int ID_W      = RCA_ID_W,
  parameter int DEPTH     = RCA_LS_QUEUE_DEPTH,
  parameter int MAX_LOADS = RCA_MAX_OUTSTANDING_LOADS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rca_ls_valid,
  output logic                            rca_ls_ready,
  input  logic [XLEN-1:0]                 rca_rs1,
  input  logic [XLEN-1:0]                 rca_rs2,
  input  logic [2:0]                      rca_fn3,
  input  logic                            rca_load,
  input  logic                            rca_store,
  input  logic [ID_W-1:0]                 rca_id,
  input  logic                            rca_flush,
  output logic                            ls_new_request,
  output logic [XLEN-1:0]                 ls_request_rs1,
  output logic [XLEN-1:0]                 ls_request_rs2,
  output logic [2:0]                      ls_request_fn3,
  output logic                            ls_request_load,
  output logic                            ls_request_store,
  output logic [ID_W-1:0]                 ls_request_id,
  input  logic                            lsu_ready,
  input  logic                            load_complete,
  input  logic [XLEN-1:0]                 load_data,
  output logic                            rca_load_complete,
  output logic [XLEN-1:0]                 rca_load_data,
  output logic                            rca_lsu_lock,
  output logic [$clog2(MAX_LOADS+1)-1:0]  loads_outstanding,
  output logic                            protocol_error
);

  localparam int CW = $clog2(MAX_LOADS + 1);

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      fn3;
    logic            load;
    logic            store;
    logic [ID_W-1:0] id;
  } req_t;

  req_t          push_req;
  req_t          head;
  logic          full;
  logic          empty;
  logic          accept;
  logic          malformed;
  logic          push;
  logic          load_issue;
  logic          unexpected_cpl;
  logic [CW-1:0] load_cnt;

  assign rca_ls_ready = !full && !rca_flush;
  assign accept       = rca_ls_valid && rca_ls_ready;
  assign malformed    = accept && is_malformed(rca_load, rca_store);
  assign push         = accept && !malformed;

  always_comb begin
    push_req       = '0;
    push_req.rs1   = rca_rs1;
    push_req.rs2   = rca_rs2;
    push_req.fn3   = rca_fn3;
    push_req.load  = rca_load;
    push_req.store = rca_store;
    push_req.id    = rca_id;
  end

  rca_ls_request_fifo #(
    .entry_t (req_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_req),
    .pop       (ls_new_request),
    .flush     (rca_flush),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // A load at the head stalls everything behind it while the load budget is spent.
  assign ls_new_request = !empty && lsu_ready && !rca_flush &&
                          (head.store || (load_cnt < CW'(MAX_LOADS)));
  assign load_issue     = ls_new_request && head.load;
  assign unexpected_cpl = load_complete && (load_cnt == '0);

  assign ls_request_rs1   = head.rs1;
  assign ls_request_rs2   = head.rs2;
  assign ls_request_fn3   = head.fn3;
  assign ls_request_load  = head.load;
  assign ls_request_store = head.store;
  assign ls_request_id    = head.id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt <= '0;
    end else begin
      case ({load_issue, load_complete && !unexpected_cpl})
        2'b10:   load_cnt <= load_cnt + 1'b1;
        2'b01:   load_cnt <= load_cnt - 1'b1;
        default: load_cnt <= load_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      protocol_error    <= 1'b0;
      rca_load_complete <= 1'b0;
      rca_load_data     <= '0;
    end else begin
      protocol_error    <= protocol_error || malformed || unexpected_cpl;
      rca_load_complete <= load_complete;
      if (load_complete)
        rca_load_data <= load_data;
    end
  end

  assign loads_outstanding = load_cnt;
  assign rca_lsu_lock      = !empty || (load_cnt != '0);

endmodule

// File: tb/tb_rca_lsu_request_queue.sv
// Randomized plus directed bench for rca_lsu_request_queue against a queue-based model.
module tb_rca_lsu_request_queue;

  localparam int XLEN  = 32;
  localparam int ID_W  = 3;
  localparam int DEPTH = 4;
  localparam int MAXL  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            rca_ls_valid, rca_ls_ready;
  logic [XLEN-1:0] rca_rs1, rca_rs2;
  logic [2:0]      rca_fn3;
  logic            rca_load, rca_store;
  logic [ID_W-1:0] rca_id;
  logic            rca_flush;
  logic            ls_new_request;
  logic [XLEN-1:0] ls_request_rs1, ls_request_rs2;
  logic [2:0]      ls_request_fn3;
  logic            ls_request_load, ls_request_store;
  logic [ID_W-1:0] ls_request_id;
  logic            lsu_ready, load_complete;
  logic [XLEN-1:0] load_data;
  logic            rca_load_complete;
  logic [XLEN-1:0] rca_load_data;
  logic            rca_lsu_lock;
  logic [2:0]      loads_outstanding;
  logic            protocol_error;

  always #5 clk = ~clk;

  rca_lsu_request_queue dut (
    .clk(clk), .rst(rst),
    .rca_ls_valid(rca_ls_valid), .rca_ls_ready(rca_ls_ready),
    .rca_rs1(rca_rs1), .rca_rs2(rca_rs2), .rca_fn3(rca_fn3),
    .rca_load(rca_load), .rca_store(rca_store), .rca_id(rca_id),
    .rca_flush(rca_flush),
    .ls_new_request(ls_new_request),
    .ls_request_rs1(ls_request_rs1), .ls_request_rs2(ls_request_rs2),
    .ls_request_fn3(ls_request_fn3), .ls_request_load(ls_request_load),
    .ls_request_store(ls_request_store), .ls_request_id(ls_request_id),
    .lsu_ready(lsu_ready), .load_complete(load_complete), .load_data(load_data),
    .rca_load_complete(rca_load_complete), .rca_load_data(rca_load_data),
    .rca_lsu_lock(rca_lsu_lock), .loads_outstanding(loads_outstanding),
    .protocol_error(protocol_error)
  );

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  fn3;
    logic        ld;
    logic        st;
    logic [2:0]  id;
  } ent_t;

  ent_t        mq[$];
  int          mcnt;
  bit          merr, mrlc;
  logic [31:0] mrld;

  int checks   = 0;
  int failures = 0;

  logic        s_ready, s_new, s_store, s_lock, s_err, s_rlc;
  logic [31:0] s_rs1, s_rs2, s_rld;
  logic [2:0]  s_fn3, s_id, s_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mcnt = 0;
    merr = 0;
    mrlc = 0;
    mrld = '0;
  endtask

  // One cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    ent_t h;
    bit   e_ready, e_new, acc, bad, unexp;
    @(negedge clk);
    h       = '{default: '0};
    if (mq.size() > 0) h = mq[0];
    e_ready = (mq.size() < DEPTH) && !rca_flush;
    e_new   = (mq.size() > 0) && lsu_ready && !rca_flush && (h.st || mcnt < MAXL);

    chk("rca_ls_ready", rca_ls_ready, e_ready);
    chk("ls_new_request", ls_new_request, e_new);
    chk("ls_request_rs1", ls_request_rs1, h.rs1);
    chk("ls_request_rs2", ls_request_rs2, h.rs2);
    chk("ls_request_fn3", ls_request_fn3, h.fn3);
    chk("ls_request_load", ls_request_load, h.ld);
    chk("ls_request_store", ls_request_store, h.st);
    chk("ls_request_id", ls_request_id, h.id);
    chk("rca_load_complete", rca_load_complete, mrlc);
    chk("rca_load_data", rca_load_data, mrld);
    chk("rca_lsu_lock", rca_lsu_lock, (mq.size() > 0) || (mcnt != 0));
    chk("loads_outstanding", loads_outstanding, mcnt);
    chk("protocol_error", protocol_error, merr);

    s_ready = rca_ls_ready;  s_new = ls_new_request;  s_rs1 = ls_request_rs1;
    s_rs2 = ls_request_rs2;  s_fn3 = ls_request_fn3;  s_store = ls_request_store;
    s_id = ls_request_id;    s_lock = rca_lsu_lock;   s_cnt = loads_outstanding;
    s_err = protocol_error;  s_rlc = rca_load_complete; s_rld = rca_load_data;

    acc   = rca_ls_valid && e_ready;
    bad   = acc && (rca_load == rca_store);
    unexp = load_complete && (mcnt == 0);
    if (e_new && h.ld) mcnt++;
    if (load_complete && !unexp) mcnt--;
    if (bad || unexp) merr = 1;
    mrlc = load_complete;
    if (load_complete) mrld = load_data;
    if (e_new) void'(mq.pop_front());
    if (rca_flush) mq.delete();
    else if (acc && !bad)
      mq.push_back('{rs1: rca_rs1, rs2: rca_rs2, fn3: rca_fn3, ld: rca_load, st: rca_store, id: rca_id});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit lr);
    rca_ls_valid = 0; rca_rs1 = '0; rca_rs2 = '0; rca_fn3 = '0;
    rca_load = 0; rca_store = 0; rca_id = '0; rca_flush = 0;
    load_complete = 0; load_data = '0; lsu_ready = lr;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                     input bit l, input bit s, input logic [2:0] i, input bit lr);
    idle(lr);
    rca_ls_valid = 1; rca_rs1 = a; rca_rs2 = b; rca_fn3 = f;
    rca_load = l; rca_store = s; rca_id = i;
  endtask

  task automatic do_reset();
    idle(0);
    rst = 1;
    model_clear();
    tick();
    tick();
    rst = 0;
    model_clear();
  endtask

  task automatic drain(input string name);
    idle(1);
    for (int n = 0; n < 40; n++) begin
      if (mcnt == 0 && mq.size() == 0) break;
      load_complete = (mcnt > 0);
      load_data     = $urandom;
      tick();
    end
    idle(1);
    tick();
    chk(name, s_lock, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    do_reset();
    idle(0);
    tick();
    chk("reset_ready", s_ready, 1);
    chk("reset_lock", s_lock, 0);
    chk("reset_err", s_err, 0);

    // Single store
    req(32'h1000, 32'hAB, 3'd2, 0, 1, 3'd3, 1);
    tick();
    chk("store_no_bypass", s_new, 0);
    idle(1);
    tick();
    chk("store_issue", s_new, 1);
    chk("store_rs1", s_rs1, 32'h1000);
    chk("store_rs2", s_rs2, 32'hAB);
    chk("store_fn3", s_fn3, 3'd2);
    chk("store_type", s_store, 1);
    chk("store_id", s_id, 3'd3);
    chk("store_lock_hi", s_lock, 1);
    tick();
    chk("store_lock_lo", s_lock, 0);

    // Fill to DEPTH with the LSU stalled, then release
    for (int i = 0; i < 5; i++) begin
      req(32'h2000 + i, i, 3'd0, 0, 1, 3'(i), 0);
      tick();
      chk("fill_ready", s_ready, (i < 4) ? 1 : 0);
    end
    idle(1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fill_issue", s_new, 1);
      chk("fill_order", s_rs1, 32'h2000 + i);
    end
    tick();
    chk("fill_done", s_new, 0);

    // Load limit
    for (int i = 0; i < 6; i++) begin
      req(32'h3000 + i, 0, 3'd2, 1, 0, 3'(i), 1);
      tick();
    end
    idle(1);
    tick();
    chk("ll_count", s_cnt, 4);
    chk("ll_held", s_new, 0);
    chk("ll_head", s_rs1, 32'h3004);
    idle(1);
    load_complete = 1;
    load_data     = 32'hDEADBEEF;
    tick();
    idle(1);
    tick();
    chk("ll_ret_vld", s_rlc, 1);
    chk("ll_ret_dat", s_rld, 32'hDEADBEEF);
    chk("ll_fifth", s_new, 1);
    chk("ll_fifth_rs1", s_rs1, 32'h3004);
    drain("ll_drain_lock");

    // Load issue and completion in the same cycle at count 2
    req(32'h4000, 0, 3'd2, 1, 0, 3'd1, 1); tick();
    req(32'h4001, 0, 3'd2, 1, 0, 3'd2, 1); tick();
    req(32'h4002, 0, 3'd2, 1, 0, 3'd3, 1); tick();
    idle(1);
    load_complete = 1;
    load_data     = 32'h55;
    tick();
    chk("sim_cnt_before", s_cnt, 2);
    chk("sim_issue", s_new, 1);
    idle(1);
    tick();
    chk("sim_cnt_after", s_cnt, 2);
    drain("sim_drain_lock");

    // Flush with one load outstanding
    req(32'h5000, 0, 3'd2, 1, 0, 3'd0, 1); tick();
    req(32'h5001, 7, 3'd0, 0, 1, 3'd1, 1); tick();
    req(32'h5002, 8, 3'd0, 0, 1, 3'd2, 0); tick();
    req(32'h5003, 9, 3'd0, 0, 1, 3'd3, 0); tick();
    idle(1);
    rca_flush = 1;
    tick();
    chk("flush_ready", s_ready, 0);
    chk("flush_no_issue", s_new, 0);
    idle(1);
    tick();
    chk("flush_empty", s_new, 0);
    chk("flush_lock", s_lock, 1);
    chk("flush_cnt", s_cnt, 1);
    idle(1);
    load_complete = 1;
    load_data     = 32'h1234;
    tick();
    chk("flush_lock_cpl", s_lock, 1);
    idle(1);
    tick();
    chk("flush_lock_drop", s_lock, 0);
    chk("flush_ret_vld", s_rlc, 1);
    chk("flush_ret_dat", s_rld, 32'h1234);

    // Protocol errors
    req(32'h6000, 0, 3'd0, 1, 1, 3'd0, 1);
    tick();
    chk("err_handshake", s_ready, 1);
    idle(1);
    tick();
    chk("err_not_issued", s_new, 0);
    chk("err_set", s_err, 1);
    chk("err_no_lock", s_lock, 0);
    idle(1);
    load_complete = 1;
    load_data     = 32'h77;
    tick();
    idle(1);
    tick();
    chk("err_cnt_zero", s_cnt, 0);
    chk("err_sticky", s_err, 1);

    // Randomized traffic, with a reset part-way through
    for (int c = 0; c < 2500; c++) begin
      int r;
      if (c == 1200) do_reset();
      idle($urandom_range(0, 99) < 70);
      rca_ls_valid = ($urandom_range(0, 99) < 60);
      r = $urandom_range(0, 49);
      rca_load  = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : r[0];
      rca_store = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : !r[0];
      rca_rs1   = $urandom;
      rca_rs2   = $urandom;
      rca_fn3   = 3'($urandom);
      rca_id    = 3'($urandom);
      rca_flush = ($urandom_range(0, 99) < 3);
      load_complete = (mcnt > 0) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 2);
      load_data = $urandom;
      tick();
    end

    do_reset();
    idle(0);
    tick();
    chk("final_err_clear", s_err, 0);
    chk("final_lock", s_lock, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
